// File: rtl/dmem_stream_pkg.sv
// Shared types and frame geometry for the image-ROM stream reader.
package dmem_stream_pkg;
    localparam int unsigned IMG_WIDTH  = 90;
    localparam int unsigned IMG_HEIGHT = 90;
    localparam int unsigned IMG_WORDS  = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned DATA_W     = 32;

    typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;
endpackage

// File: rtl/dmem_stream_pos_cnt.sv
// Frame position counter: ROM address plus column-in-row, with row/frame markers.
module dmem_stream_pos_cnt #(
    parameter int unsigned DEPTH = 8100,
    parameter int unsigned WIDTH = 90,
    parameter int unsigned AW    = 13,
    parameter int unsigned CW    = 7
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic          clr_i,
    output logic [AW-1:0] addr_o,
    output logic          sol_o,
    output logic          eol_o,
    output logic          last_o
);
    logic [AW-1:0] addr_d, addr_q;
    logic [CW-1:0] col_d, col_q;

    assign addr_o = addr_q;
    assign sol_o  = (col_q == '0);
    assign eol_o  = (col_q == CW'(WIDTH - 1));
    assign last_o = (addr_q == AW'(DEPTH - 1));

    always_comb begin
        addr_d = addr_q;
        col_d  = col_q;
        if (clr_i) begin
            addr_d = '0;
            col_d  = '0;
        end else if (en_i) begin
            // The address parks on the final word; only a clear moves it back.
            if (!last_o) addr_d = addr_q + 1'b1;
            col_d = eol_o ? '0 : col_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            addr_q <= '0;
            col_q  <= '0;
        end else begin
            addr_q <= addr_d;
            col_q  <= col_d;
        end
    end
endmodule

// File: rtl/dmem_stream_reader.sv
// Walks the image ROM once per start pulse and presents it as a valid/ready pixel stream.
module dmem_stream_reader
    import dmem_stream_pkg::*;
#(
    parameter int unsigned DEPTH  = IMG_WORDS,
    parameter int unsigned WIDTH  = IMG_WIDTH,
    parameter int unsigned DATA_W = dmem_stream_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [31:0]       rom_addr,
    input  logic [DATA_W-1:0] rom_rd,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sol,
    output logic              m_eol,
    output logic              m_last,
    output logic              busy,
    output logic              done
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e            state_d, state_q;
    logic              valid_d, valid_q;
    logic [DATA_W-1:0] data_d, data_q;
    logic              sol_d, sol_q, eol_d, eol_q, last_d, last_q;
    logic              done_d, done_q;
    logic              cnt_en, cnt_clr, pos_sol, pos_eol, pos_last, load;
    logic [AW-1:0]     addr;

    dmem_stream_pos_cnt #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW),
        .CW    (CW)
    ) u_pos_cnt (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (cnt_en),
        .clr_i  (cnt_clr),
        .addr_o (addr),
        .sol_o  (pos_sol),
        .eol_o  (pos_eol),
        .last_o (pos_last)
    );

    // Output register is free when empty or being emptied this edge.
    assign load = !valid_q || m_ready;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        data_d  = data_q;
        sol_d   = sol_q;
        eol_d   = eol_q;
        last_d  = last_q;
        done_d  = 1'b0;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        if (abort) begin
            state_d = StIdle;
            valid_d = 1'b0;
            sol_d   = 1'b0;
            eol_d   = 1'b0;
            last_d  = 1'b0;
            cnt_clr = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_clr = 1'b1;
                    if (start) state_d = StStream;
                end
                StStream: begin
                    if (load) begin
                        valid_d = 1'b1;
                        data_d  = rom_rd;
                        sol_d   = pos_sol;
                        eol_d   = pos_eol;
                        last_d  = pos_last;
                        cnt_en  = 1'b1;
                        if (pos_last) state_d = StDrain;
                    end
                end
                StDrain: begin
                    if (valid_q && m_ready) begin
                        valid_d = 1'b0;
                        sol_d   = 1'b0;
                        eol_d   = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        cnt_clr = 1'b1;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            data_q  <= '0;
            sol_q   <= 1'b0;
            eol_q   <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            sol_q   <= sol_d;
            eol_q   <= eol_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign rom_addr = 32'(addr);
    assign m_valid  = valid_q;
    assign m_data   = data_q;
    assign m_sol    = sol_q;
    assign m_eol    = eol_q;
    assign m_last   = last_q;
    assign done     = done_q;
    assign busy     = (state_q != StIdle);
endmodule

// File: tb/tb_dmem_stream_reader.sv
// Randomised and directed checks of the stream reader against a word-index model.
module tb_dmem_stream_reader;
    localparam int unsigned SD = 12;
    localparam int unsigned SW = 4;
    localparam int unsigned DD = 8100;
    localparam int unsigned DW = 90;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, abort, m_ready;
    logic [31:0] s_addr, s_rd, s_data;
    logic        s_valid, s_sol, s_eol, s_last, s_busy, s_done;

    logic        d_rst_n, d_start, d_abort, d_ready;
    logic [31:0] d_addr, d_rd, d_data;
    logic        d_valid, d_sol, d_eol, d_last, d_busy, d_done;
    bit          d_finished = 1'b0;

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] rom_s(input int unsigned a);
        return 32'(a * 3 + 1);
    endfunction

    function automatic logic [31:0] rom_d(input int unsigned a);
        return 32'(a) * 32'h9E37_79B1 + 32'd7;
    endfunction

    assign s_rd = rom_s(s_addr);
    assign d_rd = rom_d(d_addr);

    dmem_stream_reader #(.DEPTH(SD), .WIDTH(SW), .DATA_W(32)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .rom_addr(s_addr),
        .rom_rd(s_rd), .m_valid(s_valid), .m_ready(m_ready), .m_data(s_data),
        .m_sol(s_sol), .m_eol(s_eol), .m_last(s_last), .busy(s_busy), .done(s_done)
    );

    dmem_stream_reader u_full (
        .clk(clk), .rst_n(d_rst_n), .start(d_start), .abort(d_abort), .rom_addr(d_addr),
        .rom_rd(d_rd), .m_valid(d_valid), .m_ready(d_ready), .m_data(d_data),
        .m_sol(d_sol), .m_eol(d_eol), .m_last(d_last), .busy(d_busy), .done(d_done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Model: which word index is on the output (-1 = none) and which one comes next.
    bit m_active = 1'b0;
    int m_shown  = -1;
    int m_next   = 0;
    bit m_done   = 1'b0;
    bit mdl_on   = 1'b0;

    task automatic model_step();
        if (!rst_n || abort) begin
            m_active = 1'b0;
            m_shown  = -1;
            m_next   = 0;
            m_done   = 1'b0;
        end else begin
            m_done = 1'b0;
            if (!m_active) begin
                if (start) begin
                    m_active = 1'b1;
                    m_next   = 0;
                end
            end else if (m_shown < 0 || m_ready) begin
                if (m_next < int'(SD)) begin
                    m_shown = m_next;
                    m_next++;
                end else begin
                    m_shown  = -1;
                    m_next   = 0;
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (mdl_on) begin
            chk("valid", s_valid, m_shown >= 0);
            chk("busy", s_busy, m_active);
            chk("done", s_done, m_done);
            chk("rom_addr", s_addr,
                m_active ? ((m_next < int'(SD)) ? m_next : SD - 1) : 0);
            if (m_shown >= 0) begin
                chk("data", s_data, rom_s(m_shown));
                chk("sol", s_sol, (m_shown % SW) == 0);
                chk("eol", s_eol, (m_shown % SW) == SW - 1);
                chk("last", s_last, m_shown == int'(SD) - 1);
            end
        end
        model_step();
        mdl_on = 1'b1;
    end

    int          cap_n, cap_cycles, cap_stalls;
    logic [31:0] cap_data [16];
    logic [15:0] sol_mask, eol_mask, last_mask;

    task automatic run_frame(input bit tog);
        cap_n = 0; cap_stalls = 0;
        sol_mask = '0; eol_mask = '0; last_mask = '0;
        m_ready = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cap_cycles = 1;
        while (!s_done && cap_cycles < 200) begin
            if (tog) m_ready = ~m_ready;
            if (s_valid && m_ready) begin
                if (cap_n < 16) begin
                    cap_data[cap_n]  = s_data;
                    sol_mask[cap_n]  = s_sol;
                    eol_mask[cap_n]  = s_eol;
                    last_mask[cap_n] = s_last;
                end
                cap_n++;
            end
            if (s_valid && !m_ready) cap_stalls++;
            cyc();
            cap_cycles++;
        end
        m_ready = 1'b1;
    endtask

    task automatic check_frame(input string tag);
        chk({tag, " count"}, cap_n, 12);
        chk({tag, " w0"}, cap_data[0], 1);
        chk({tag, " w1"}, cap_data[1], 4);
        chk({tag, " w5"}, cap_data[5], 16);
        chk({tag, " w11"}, cap_data[11], 34);
        chk({tag, " sol"}, sol_mask, 16'h0111);
        chk({tag, " eol"}, eol_mask, 16'h0888);
        chk({tag, " last"}, last_mask, 16'h0800);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b1;
        repeat (3) cyc();
        chk("rst valid", s_valid, 0);
        chk("rst data", s_data, 0);
        chk("rst busy", s_busy, 0);
        rst_n = 1'b1;
        cyc();

        // Clean frame, then a frame with alternating backpressure.
        run_frame(1'b0);
        check_frame("plain");
        chk("plain cycles", cap_cycles, 14);
        cyc();
        chk("done width", s_done, 0);
        run_frame(1'b1);
        check_frame("stall");
        chk("stall seen", cap_stalls > 0, 1);
        chk("stall cycles", cap_cycles, 14 + cap_stalls);

        // Abort while word 5 is presented.
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 30 && !(s_valid && s_data == 16); i++) cyc();
        chk("abort at w5", s_data, 16);
        abort = 1'b1; cyc(); abort = 1'b0;
        chk("abort valid", s_valid, 0);
        chk("abort busy", s_busy, 0);
        chk("abort done", s_done, 0);
        cyc();
        chk("abort done later", s_done, 0);
        run_frame(1'b0);
        check_frame("after abort");

        // Restart attempts while busy, and start+abort together in idle.
        start = 1'b1; cyc(); start = 1'b0;
        repeat (3) cyc();
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 40 && !s_done; i++) cyc();
        chk("busy start done", s_done, 1);
        cyc();
        start = 1'b1; abort = 1'b1; cyc(); start = 1'b0; abort = 1'b0;
        chk("start+abort busy", s_busy, 0);
        cyc();
        chk("start+abort valid", s_valid, 0);

        // Reset while word 6 waits under backpressure.
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 30 && !(s_valid && s_data == 19); i++) cyc();
        chk("reset at w6", s_data, 19);
        m_ready = 1'b0; cyc();
        rst_n = 1'b0; cyc();
        chk("mid rst valid", s_valid, 0);
        chk("mid rst data", s_data, 0);
        chk("mid rst flags", {s_sol, s_eol, s_last, s_done, s_busy}, 0);
        chk("mid rst addr", s_addr, 0);
        rst_n = 1'b1; m_ready = 1'b1;
        run_frame(1'b0);
        check_frame("after reset");

        // Random traffic, checked by the model every cycle.
        for (int i = 0; i < 600; i++) begin
            start   = ($urandom_range(7) == 0);
            abort   = ($urandom_range(40) == 0);
            m_ready = ($urandom_range(2) != 0);
            rst_n   = ($urandom_range(150) != 0);
            cyc();
        end
        rst_n = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b1;
        repeat (3) cyc();

        wait (d_finished);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Full-size frame on the default configuration.
    initial begin
        int idx, eols, last_idx, cycles;
        d_rst_n = 1'b0; d_start = 1'b0; d_abort = 1'b0; d_ready = 1'b1;
        repeat (3) cyc();
        d_rst_n = 1'b1;
        cyc();
        d_start = 1'b1; cyc(); d_start = 1'b0;
        idx = 0; eols = 0; last_idx = -1; cycles = 1;
        while (!d_done && cycles < 9000) begin
            if (d_valid) begin
                chk("full data", d_data, rom_d(idx));
                chk("full sol", d_sol, (idx % DW) == 0);
                if (d_eol) eols++;
                if (d_last) last_idx = idx;
                idx++;
            end
            cyc();
            cycles++;
        end
        chk("full words", idx, DD);
        chk("full eols", eols, 90);
        chk("full last", last_idx, DD - 1);
        chk("full cycles", cycles, DD + 2);
        chk("full busy", d_busy, 0);
        d_finished = 1'b1;
    end
endmodule
